// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the default memory-acknowledge timeout.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian byte/half lane handling: extended load data and the merged
// word for sub-word stores, both derived from the same memory word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sext;

    always_comb begin
        lane_b   = word_i[{offset_i, 3'b000} +: 8];
        lane_h   = word_i[{offset_i[1], 4'b0000} +: 16];
        sext     = !unsigned_i;
        load_o   = word_i;
        merged_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                load_o = {{24{sext & lane_b[7]}}, lane_b};
                merged_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o = {{16{sext & lane_h[15]}}, lane_h};
                merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: alignment check, memory strobes with ack
// timeout, lane extraction on loads and read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [31:0]       mem_data_i,
    input  logic              mem_ack_i
);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [31:0]       data_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              hold_q;
    logic [7:0]        cnt_q;
    logic              illegal;
    logic              mem_state;
    logic              timeout;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    assign illegal   = (req_size_i == 2'b11)
                    || (req_size_i == SZ_HALF && req_addr_i[0])
                    || (req_size_i == SZ_WORD && req_addr_i[1:0] != 2'b00);
    assign mem_state = state_q inside {S_READ, S_WRITE, S_RMW_RD, S_RMW_WR};
    assign timeout   = mem_state && !mem_ack_i && (cnt_q == 8'(TIMEOUT - 1));

    lsu_lane_align u_align (
        .word_i     (mem_data_i),
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .wdata_i    (data_q),
        .load_o     (load_data),
        .merged_o   (merged)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid_i) begin
                if (illegal)             state_d = S_RESP;
                else if (!req_write_i)   state_d = S_READ;
                else if (req_size_i == SZ_WORD) state_d = S_WRITE;
                else                     state_d = S_RMW_RD;
            end
            S_READ, S_WRITE, S_RMW_WR: if (mem_ack_i || timeout) state_d = S_RESP;
            S_RMW_RD: begin
                if (mem_ack_i)    state_d = S_RMW_WR;
                else if (timeout) state_d = S_RESP;
            end
            S_RESP:  if (!hold_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Illegal requests spend one extra cycle in RESP (hold_q) so their
    // response latency matches a zero-wait memory access.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            data_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            hold_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid_i) begin
                    addr_q     <= req_addr_i;
                    size_q     <= req_size_i;
                    unsigned_q <= req_unsigned_i;
                    data_q     <= req_wdata_i;
                    rdata_q    <= '0;
                    err_q      <= illegal;
                    hold_q     <= illegal;
                end
                S_READ: begin
                    if (mem_ack_i)    rdata_q <= load_data;
                    else if (timeout) err_q   <= 1'b1;
                end
                S_RMW_RD: begin
                    if (mem_ack_i)    data_q <= merged;
                    else if (timeout) err_q  <= 1'b1;
                end
                S_WRITE, S_RMW_WR: if (timeout) err_q <= 1'b1;
                S_RESP:  hold_q <= 1'b0;
                default: ;
            endcase
            if (state_d != state_q) cnt_q <= '0;
            else if (mem_state)     cnt_q <= cnt_q + 8'd1;
        end
    end

    always_comb begin
        req_ready_o  = (state_q == S_IDLE);
        resp_valid_o = (state_q == S_RESP) && !hold_q;
        resp_rdata_o = ((state_q == S_RESP) && !hold_q) ? rdata_q : '0;
        resp_err_o   = (state_q == S_RESP) && !hold_q && err_q;
        mem_read_o   = (state_q == S_READ)  || (state_q == S_RMW_RD);
        mem_write_o  = (state_q == S_WRITE) || (state_q == S_RMW_WR);
        mem_addr_o   = {addr_q[ADDR_W-1:2], 2'b00};
        mem_data_o   = ((state_q == S_WRITE) || (state_q == S_RMW_WR)) ? data_q : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a 16-word memory responder with
// programmable ack delay, an arithmetic reference model and a response monitor.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_o;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data_i;
    logic        mem_ack = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
        int unsigned rd_cyc;
        int unsigned wr_cyc;
        int unsigned widx;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] phys_mem[16];
    logic [31:0] ref_mem[16];
    int unsigned vectors = 0, miscompares = 0, cyc = 0;
    int unsigned ack_delay = 0, wait_cnt = 0, n_rd = 0, n_wr = 0;
    bit          ack_never = 1'b0, prev_hs = 1'b0, prev_act = 1'b0;
    logic        prev_rd, prev_wr;
    logic [31:0] prev_addr, prev_data;

    always #5 clk = ~clk;
    assign mem_data_i = phys_mem[mem_addr[5:2]];

    load_store_unit #(.ADDR_W(32), .TIMEOUT(255)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
        .resp_err_o(resp_err), .mem_addr_o(mem_addr), .mem_data_o(mem_data_o),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_data_i(mem_data_i),
        .mem_ack_i(mem_ack)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor, then memory responder, in one negedge process to avoid races.
    always @(negedge clk) begin
        bit act;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            prev_hs = 0; prev_act = 0; wait_cnt = 0; mem_ack = 1'b0;
        end else begin
            act = mem_read || mem_write;
            chk("strobe_mutex", {31'b0, mem_read && mem_write}, 0);
            if (act) begin
                chk("ready_low_busy", {31'b0, req_ready}, 0);
                chk("addr_word_aligned", {30'b0, mem_addr[1:0]}, 0);
            end
            if (prev_act && !prev_hs && act) begin
                chk("stable_read", {31'b0, mem_read}, {31'b0, prev_rd});
                chk("stable_write", {31'b0, mem_write}, {31'b0, prev_wr});
                chk("stable_addr", mem_addr, prev_addr);
                chk("stable_data", mem_data_o, prev_data);
            end
            if (resp_valid) begin
                chk("resp_expected", {31'b0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    chk("resp_cycle", cyc, e.cyc);
                    chk("read_strobe_cycles", n_rd, e.rd_cyc);
                    chk("write_strobe_cycles", n_wr, e.wr_cyc);
                    chk("mem_word", phys_mem[e.widx], e.word);
                end
            end
            if (mem_read)  n_rd++;
            if (mem_write) n_wr++;
            if (prev_hs) wait_cnt = 0;
            if (act) begin
                mem_ack = !ack_never && (wait_cnt == ack_delay);
                wait_cnt++;
                if (mem_ack && mem_write) phys_mem[mem_addr[5:2]] = mem_data_o;
            end else begin
                wait_cnt = 0;
                mem_ack  = 1'($urandom % 2);
            end
            prev_hs = act && mem_ack; prev_act = act;
            prev_rd = mem_read; prev_wr = mem_write;
            prev_addr = mem_addr; prev_data = mem_data_o;
        end
    end

    task automatic issue(input bit wr, input logic [1:0] sz, input bit uns, input logic [5:0] a,
                         input logic [31:0] wd, input int unsigned d, input bit never, input bit push);
        exp_t e;
        int unsigned bound = 0, acc, off, idx, nb, lat;
        longint unsigned w, v, lim, mask;
        bit illegal;
        @(posedge clk); #1;
        while (!req_ready && bound < 1000) begin @(posedge clk); #1; bound++; end
        if (!req_ready) begin
            chk("ready_wait", {31'b0, req_ready}, 1);
            return;
        end
        ack_delay = d; ack_never = never;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = 32'(a); req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_rd = 0; n_wr = 0; acc = cyc;
        off = a % 4; idx = a / 4; nb = 1 << sz;
        illegal = (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && off != 0);
        w = ref_mem[idx]; lim = 64'd1 << (8 * nb);
        e.rdata = '0; e.err = 1'b0; e.rd_cyc = 0; e.wr_cyc = 0;
        if (illegal) begin
            e.err = 1'b1; lat = 1;
        end else if (never) begin
            e.err = 1'b1; lat = 255;
            if (wr && nb == 4) e.wr_cyc = 255; else e.rd_cyc = 255;
        end else if (!wr) begin
            v = (w >> (8 * off)) % lim;
            if (!uns && nb < 4 && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
            e.rdata = v[31:0]; lat = 1 + d; e.rd_cyc = d + 1;
        end else if (nb == 4) begin
            ref_mem[idx] = wd; lat = 1 + d; e.wr_cyc = d + 1;
        end else begin
            mask = (lim - 1) << (8 * off);
            v = (w & ~mask & 64'hFFFF_FFFF) | ((64'(wd) % lim) << (8 * off));
            ref_mem[idx] = v[31:0]; lat = 2 + 2 * d; e.rd_cyc = d + 1; e.wr_cyc = d + 1;
        end
        e.cyc = acc + 1 + lat; e.widx = idx; e.word = ref_mem[idx];
        if (push) exp_q.push_back(e);
    endtask

    initial begin
        int unsigned bound;
        logic [1:0] sz;
        logic [5:0] a;
        for (int i = 0; i < 16; i++) phys_mem[i] = $urandom;
        phys_mem[1] = 32'h8899_AABB;
        for (int i = 0; i < 16; i++) ref_mem[i] = phys_mem[i];

        rst_n = 1'b0;
        #2;
        chk("rst_ready", {31'b0, req_ready}, 1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", {31'b0, resp_err}, 0);
        chk("rst_strobes", {30'b0, mem_read, mem_write}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(0, SZ_BYTE, 0, 6'h5, 0, 0, 0, 1);
        issue(0, SZ_BYTE, 1, 6'h5, 0, 0, 0, 1);
        issue(0, SZ_HALF, 0, 6'h6, 0, 0, 0, 1);
        issue(0, SZ_WORD, 0, 6'h6, 0, 0, 0, 1);
        issue(1, SZ_BYTE, 0, 6'h7, 32'h11, 0, 0, 1);
        issue(1, SZ_WORD, 0, 6'h0, 32'hDEAD_BEEF, 5, 0, 1);
        issue(0, SZ_WORD, 0, 6'h8, 0, 0, 1, 1);
        issue(1, SZ_HALF, 0, 6'hA, $urandom, 0, 1, 1);

        // Reset while a read is waiting on its ack: no response may follow.
        issue(0, SZ_WORD, 0, 6'hC, 0, 0, 1, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_read_drop", {31'b0, mem_read}, 0);
        chk("midrst_ready", {31'b0, req_ready}, 1);
        chk("midrst_resp", {31'b0, resp_valid}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; ack_never = 1'b0;
        issue(0, SZ_WORD, 0, 6'hC, 0, 0, 0, 1);

        for (int n = 0; n < 150; n++) begin
            sz = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 6'($urandom);
            if ($urandom % 2 == 0 && sz != 2'b11) a = a & ~6'((1 << sz) - 1);
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 3), 0, 1);
        end

        bound = 0;
        while (exp_q.size() != 0 && bound < 600) begin @(posedge clk); bound++; end
        chk("responses_outstanding", exp_q.size(), 0);
        for (int i = 0; i < 16; i++) chk("final_mem", phys_mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage initiator for the word-organised data memory.
- Accepts one load/store request at a time from the pipeline, checks alignment, and drives the memory-side addr/data/read/write strobes.
- Performs byte-lane extraction with sign or zero extension on loads, and read-modify-write for sub-word stores.
- Returns a single-cycle response. The pipeline holds (stalls) while req_ready_o is low.

Parameters:
- ADDR_W, 32, request/memory address width
- TIMEOUT, 255, max cycles waiting for mem_ack_i before abort with error (8-bit counter)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit can accept (high only in IDLE)
- req_write_i  in  1  1=store, 0=load
- req_size_i  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned_i  in  1  zero-extend loads (lbu/lhu)
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  32  store data (low bytes used for sub-word)
- resp_valid_o  out  1  one-cycle completion pulse
- resp_rdata_o  out  32  extended load data; 0 for stores/errors
- resp_err_o  out  1  misaligned, illegal size or timeout (valid with resp_valid_o)
- mem_addr_o  out  ADDR_W  word-aligned address (req_addr & ~3)
- mem_data_o  out  32  write data to memory
- mem_read_o  out  1  read strobe
- mem_write_o  out  1  write strobe
- mem_data_i  in  32  read data from memory
- mem_ack_i  in  1  memory completed current strobe

Behaviour:
- Reset (async, rst_n_i low): state IDLE; all outputs 0 except req_ready_o=1. Reset mid-operation drops strobes immediately; the in-flight request is lost with no response.
- Accept: in IDLE, a request is accepted when req_valid_i && req_ready_o. Request fields are registered and the unit leaves IDLE the next cycle.
- Legality check: misaligned half (addr[0]=1), misaligned word (addr[1:0]!=0) or size 11 -> state RESP with err=1, no memory strobe issued.
- States: IDLE, READ, WRITE, RMW_RD, RMW_WR, RESP.
  - IDLE -> READ on load.
  - IDLE -> WRITE on word store.
  - IDLE -> RMW_RD on byte/half store.
  - READ: mem_read_o=1. On mem_ack_i, capture mem_data_i, extract lane -> RESP.
  - WRITE: mem_write_o=1, mem_data_o=wdata. On ack -> RESP.
  - RMW_RD: mem_read_o=1. On ack, merge: replace addressed byte/half of mem_data_i with wdata low bits -> RMW_WR.
  - RMW_WR: mem_write_o=1 with merged word. On ack -> RESP.
  - RESP: resp_valid_o=1 for exactly one cycle -> IDLE.
- No response backpressure.
- Strobes, mem_addr_o and mem_data_o are stable from entry to a state until the cycle mem_ack_i is sampled high. mem_read_o and mem_write_o are never both 1.
- mem_ack_i outside READ/WRITE/RMW states is ignored.
- Lanes are little-endian: byte k = bits [8k+7:8k], half h = bits [16h+15:16h].
- Loads sign-extend unless req_unsigned_i.
- Timeout: the counter clears on entering each memory state and increments per cycle without ack. When it reaches TIMEOUT: drop strobe -> RESP with err=1. An RMW aborted in RMW_RD performs no write.
- Latency, ack in same cycle as strobe: accept at T, strobe at T+1, resp_valid at T+2 (load/word store); T+3 for RMW; T+2 for alignment error.
- Throughput: one request per 3 cycles minimum.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum lsu_state_t
  - TIMEOUT default
- One combinational sub-module, lsu_lane_align: inputs word, offset, size, unsigned, wdata; outputs extended load data and merged store word. Shared by READ and RMW_RD paths.

Test Plan:
- Memory holds 0x8899AABB at 0x4, lb addr 0x5, ack same cycle as strobe -> resp_valid at T+2, rdata 0xFFFFFFAA, err 0. Same with lbu -> 0x000000AA.
- lh addr 0x6 on the same word -> rdata 0xFFFF8899. lw addr 0x6 -> no strobe, resp_err=1, rdata 0, response at T+2.
- sb wdata 0x11 addr 0x7 on word 0x8899AABB -> one read then one write of 0x1199AABB to mem_addr 0x4, resp at T+3.
- sw 0xDEADBEEF addr 0x0, ack delayed 5 cycles -> mem_write_o/addr/data held stable 5 cycles, req_ready_o low throughout, single resp pulse after ack.
- Load with mem_ack_i never asserted -> strobe drops after 255 cycles, resp_err=1. sh whose RMW read times out -> mem_write_o never asserted.
- Assert rst_n_i low mid-READ -> mem_read_o falls asynchronously, no resp_valid_o. After release, req_ready_o=1 and the next lw completes normally.
